keypad_scanner: RTL and testbench

//  Column-driving end of the PmodKYPD interface on JA: drives JA[3:0] columns

---
 rtl/bomberman_pkg.sv | 55 +++++
 rtl/keypad_col_timer.sv | 42 ++++
 rtl/keypad_scanner.sv | 163 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// Shared definitions for the bomberman keypad path (scanner and chara_control).
// Contents: hex key-code constants, 4x4 PmodKYPD key map, scanner enums.
// Key map rows are top to bottom and columns left to right, as seen on the pad.
package bomberman_pkg;

  localparam logic [3:0] KEY_0 = 4'h0;
  localparam logic [3:0] KEY_1 = 4'h1;
  localparam logic [3:0] KEY_2 = 4'h2;
  localparam logic [3:0] KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4;
  localparam logic [3:0] KEY_5 = 4'h5;
  localparam logic [3:0] KEY_6 = 4'h6;
  localparam logic [3:0] KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8;
  localparam logic [3:0] KEY_9 = 4'h9;
  localparam logic [3:0] KEY_A = 4'hA;
  localparam logic [3:0] KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;
  localparam logic [3:0] KEY_F = 4'hF;

  // Outcome of one full 4-column scan.
  typedef enum logic [1:0] {SCAN_NONE, SCAN_SINGLE, SCAN_MULTI} scan_res_t;

  // Press/release state machine states.
  typedef enum logic [1:0] {ST_SCAN, ST_REPORT, ST_HELD} kp_state_t;

  // Physical (row, col) position to hex code.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = KEY_0;
    case ({r, c})
      4'h0: k = KEY_1;
      4'h1: k = KEY_2;
      4'h2: k = KEY_3;
      4'h3: k = KEY_A;
      4'h4: k = KEY_4;
      4'h5: k = KEY_5;
      4'h6: k = KEY_6;
      4'h7: k = KEY_B;
      4'h8: k = KEY_7;
      4'h9: k = KEY_8;
      4'hA: k = KEY_9;
      4'hB: k = KEY_C;
      4'hC: k = KEY_0;
      4'hD: k = KEY_F;
      4'hE: k = KEY_E;
      4'hF: k = KEY_D;
      default: k = KEY_0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_col_timer.sv
// Column sequencer: holds each column low for DWELL_CYCLES, rotating 0->1->2->3.
// Ports: clk, reset_sw (async high) | col (registered, active-low), col_idx,
//        sample (row sample strobe at dwell cycle SETTLE_CYCLES), scan_done (last cycle of col 3).
module keypad_col_timer #(
  parameter int DWELL_CYCLES  = 100000,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_sw,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic       sample,
  output logic       scan_done
);
  import bomberman_pkg::*;

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST   = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);

  logic [CW-1:0] dwell_cnt;

  // col is its own register so the pins never glitch through a decoder.
  always_ff @(posedge clk or posedge reset_sw) begin
    if (reset_sw) begin
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
      col       <= 4'b1110;
    end else if (dwell_cnt == LAST) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx + 2'd1;
      col       <= {col[2:0], col[3]};
    end else begin
      dwell_cnt <= dwell_cnt + ONE;
    end
  end

  assign sample    = (dwell_cnt == SETTLE);
  assign scan_done = (dwell_cnt == LAST) && (col_idx == 2'd3);

endmodule

// File: rtl/keypad_scanner.sv
// PmodKYPD scanner: drives columns, debounces one key, hands its hex code out on valid/ready.
// Ports: clk, reset_sw (async high), row (async, active-low) | col, key_code, key_valid,
//        key_ready (in), key_held, overrun (sticky lost-event flag).
module keypad_scanner #(
  parameter int DWELL_CYCLES   = 100000,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset_sw,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);
  import bomberman_pkg::*;

  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_SCANS);
  localparam logic [DW-1:0] ONE_D   = DW'(1);

  logic [1:0] col_idx;
  logic       sample;
  logic       scan_done;

  keypad_col_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_col_timer (
    .clk      (clk),
    .reset_sw (reset_sw),
    .col      (col),
    .col_idx  (col_idx),
    .sample   (sample),
    .scan_done(scan_done)
  );

  // Two-flop synchroniser; idle (all high) out of reset.
  logic [3:0] row_meta, row_sync;
  always_ff @(posedge clk or posedge reset_sw) begin
    if (reset_sw) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  logic [3:0] row_low;
  logic [2:0] row_pop;
  logic [1:0] row_enc;
  assign row_low = ~row_sync;
  assign row_pop = {2'b00, row_low[0]} + {2'b00, row_low[1]} +
                   {2'b00, row_low[2]} + {2'b00, row_low[3]};

  always_comb begin
    row_enc = 2'd0;
    if (row_low[1]) row_enc = 2'd1;
    if (row_low[2]) row_enc = 2'd2;
    if (row_low[3]) row_enc = 2'd3;
  end

  // Per-scan accumulator: hits saturates at 2 (= more than one closed contact).
  // The *_next values fold in a sample landing on the scan_done cycle itself.
  logic [1:0] hits, hits_next;
  logic [3:0] acc_code, acc_code_next;
  scan_res_t  scan_res;

  always_comb begin
    hits_next     = hits;
    acc_code_next = acc_code;
    if (sample && row_pop != 3'd0) begin
      if (hits == 2'd0 && row_pop == 3'd1) begin
        hits_next     = 2'd1;
        acc_code_next = key_map(row_enc, col_idx);
      end else begin
        hits_next = 2'd2;
      end
    end
    case (hits_next)
      2'd0:    scan_res = SCAN_NONE;
      2'd1:    scan_res = SCAN_SINGLE;
      default: scan_res = SCAN_MULTI;
    endcase
  end

  always_ff @(posedge clk or posedge reset_sw) begin
    if (reset_sw) begin
      hits     <= 2'd0;
      acc_code <= 4'h0;
    end else if (scan_done) begin
      hits     <= 2'd0;
      acc_code <= 4'h0;
    end else begin
      hits     <= hits_next;
      acc_code <= acc_code_next;
    end
  end

  kp_state_t  state;
  logic [3:0] cand;
  logic [DW-1:0] cnt, rel, cnt_inc, rel_inc;
  assign cnt_inc = (cnt == DEB_MAX) ? cnt : cnt + ONE_D;
  assign rel_inc = (rel == DEB_MAX) ? rel : rel + ONE_D;

  always_ff @(posedge clk or posedge reset_sw) begin
    if (reset_sw) begin
      state     <= ST_SCAN;
      cand      <= 4'h0;
      cnt       <= '0;
      rel       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (key_valid && key_ready) key_valid <= 1'b0;
      case (state)
        ST_SCAN: if (scan_done) begin
          if (scan_res == SCAN_SINGLE) begin
            if (acc_code_next == cand) begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB_MAX) state <= ST_REPORT;
            end else begin
              cand <= acc_code_next;
              cnt  <= ONE_D;
              if (ONE_D == DEB_MAX) state <= ST_REPORT;
            end
          end else begin
            cnt <= '0;
          end
        end
        ST_REPORT: begin
          // Overrides a same-cycle handshake clear: the new event wins.
          key_code  <= cand;
          key_valid <= 1'b1;
          key_held  <= 1'b1;
          if (key_valid && !key_ready) overrun <= 1'b1;
          rel   <= '0;
          state <= ST_HELD;
        end
        ST_HELD: if (scan_done) begin
          if (scan_res == SCAN_NONE) begin
            rel <= rel_inc;
            if (rel_inc == DEB_MAX) begin
              key_held <= 1'b0;
              cnt      <= '0;
              state    <= ST_SCAN;
            end
          end else begin
            rel <= '0;
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model drives row from col and a pressed-key mask.
// Expected events are queued by the stimulus; a monitor pops them at each handshake.
module tb_keypad_scanner;

  localparam int DWELL = 20;
  localparam int SETTLE = 4;
  localparam int DEB = 2;

  logic       clk = 1'b0;
  logic       reset_sw;
  logic       key_ready;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held, overrun;
  logic [15:0] pressed;   // bit r*4+c

  int checks = 0;
  int errors = 0;
  int rises  = 0;

  typedef struct packed {
    logic [3:0] code;
    logic       ovr;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  keypad_scanner #(
    .DWELL_CYCLES  (DWELL),
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk      (clk),
    .reset_sw (reset_sw),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_held (key_held),
    .overrun  (overrun)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] kbit(input int r, input int c);
    logic [15:0] one;
    one = 16'd1;
    return one << (r*4 + c);
  endfunction

  // Returns on the negedge in cycle 0 of the next scan.
  task automatic wait_scan();
    logic [3:0] last;
    last = col;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (col == 4'b1110 && last == 4'b0111) return;
      last = col;
    end
    checks++;
    errors++;
    $display("FAIL scan_timeout: no scan boundary within 400 cycles at %0t", $time);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic ready_pulse();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  task automatic release_all(input string name);
    pressed = '0;
    repeat (3) wait_scan();
    check(name, {7'd0, key_held}, 8'h00);
  endtask

  // Monitor: event latency on each rising key_valid, scoreboard on each handshake.
  initial begin
    logic [3:0] col_d1, col_d2;
    logic       valid_prev;
    ev_t        e;
    col_d1 = 4'hF;
    col_d2 = 4'hF;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (key_valid && !valid_prev) begin
        rises++;
        check("event_latency", {col_d2, col_d1}, 8'h7E);
      end
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got code %h, none expected", key_code);
        end else begin
          e = exp_q.pop_front();
          check("event_code", {4'h0, key_code}, {4'h0, e.code});
          check("event_overrun", {7'd0, overrun}, {7'd0, e.ovr});
        end
      end
      valid_prev = key_valid;
      col_d2 = col_d1;
      col_d1 = col;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_col;
    reset_sw  = 1'b1;
    key_ready = 1'b0;
    pressed   = '0;

    // 1: reset state and idle column walk
    repeat (3) @(negedge clk);
    check("rst_col",     {4'h0, col},      8'h0E);
    check("rst_code",    {4'h0, key_code}, 8'h00);
    check("rst_valid",   {7'd0, key_valid}, 8'h00);
    check("rst_held",    {7'd0, key_held},  8'h00);
    check("rst_overrun", {7'd0, overrun},   8'h00);
    reset_sw = 1'b0;
    #1;
    for (int i = 0; i < 8*DWELL; i++) begin
      exp_col = ~(4'b0001 << ((i / DWELL) % 4));
      check("idle_col", {4'h0, col}, {4'h0, exp_col});
      @(negedge clk);
      #1;
    end

    // 2: key 6 held 3 scans, no ready
    wait_scan();
    pressed = kbit(1, 2);
    exp_q.push_back({4'h6, 1'b0});
    repeat (3) wait_scan();
    check("k6_code",  {4'h0, key_code}, 8'h06);
    check("k6_valid", {7'd0, key_valid}, 8'h01);
    check("k6_held",  {7'd0, key_held},  8'h01);
    pressed = '0;
    ready_pulse();
    @(negedge clk);
    check("k6_hs_clear", {7'd0, key_valid}, 8'h00);
    check("k6_still_held", {7'd0, key_held}, 8'h01);
    repeat (2) wait_scan();
    check("k6_released", {7'd0, key_held}, 8'h00);

    // 3: key 5 with a bounce across the column-1 sample of the second scan
    wait_scan();
    pressed = kbit(1, 1);
    wait_scan();
    repeat (21) @(negedge clk);
    pressed = '0;
    repeat (8) @(negedge clk);
    pressed = kbit(1, 1);
    wait_scan();
    settle();
    check("bounce_no_valid", {7'd0, key_valid}, 8'h00);
    check("bounce_no_held",  {7'd0, key_held},  8'h00);
    exp_q.push_back({4'h5, 1'b0});
    wait_scan();
    settle();
    check("one_clean_no_valid", {7'd0, key_valid}, 8'h00);
    wait_scan();
    settle();
    check("k5_valid", {7'd0, key_valid}, 8'h01);
    check("k5_code",  {4'h0, key_code}, 8'h05);
    ready_pulse();
    release_all("k5_released");

    // 4: chord 1 + 8 is MULTI; releasing 8 leaves key 1
    wait_scan();
    pressed = kbit(0, 0) | kbit(2, 1);
    repeat (3) wait_scan();
    settle();
    check("multi_no_valid", {7'd0, key_valid}, 8'h00);
    check("multi_no_held",  {7'd0, key_held},  8'h00);
    pressed = kbit(0, 0);
    exp_q.push_back({4'h1, 1'b0});
    repeat (2) wait_scan();
    settle();
    check("k1_valid", {7'd0, key_valid}, 8'h01);
    check("k1_code",  {4'h0, key_code}, 8'h01);
    ready_pulse();
    release_all("k1_released");

    // 5: A then D with no ready -> D overwrites, overrun
    wait_scan();
    pressed = kbit(0, 3);
    repeat (2) wait_scan();
    settle();
    check("kA_valid",   {7'd0, key_valid}, 8'h01);
    check("kA_code",    {4'h0, key_code}, 8'h0A);
    check("kA_overrun", {7'd0, overrun},   8'h00);
    release_all("kA_released");
    pressed = kbit(3, 3);
    exp_q.push_back({4'hD, 1'b1});
    repeat (2) wait_scan();
    settle();
    check("kD_valid",   {7'd0, key_valid}, 8'h01);
    check("kD_code",    {4'h0, key_code}, 8'h0D);
    check("kD_overrun", {7'd0, overrun},   8'h01);
    ready_pulse();
    @(negedge clk);
    check("kD_hs_clear", {7'd0, key_valid}, 8'h00);
    check("overrun_sticky", {7'd0, overrun}, 8'h01);
    release_all("kD_released");

    // 6: reset mid-debounce of key 9, then it reports again
    wait_scan();
    pressed = kbit(2, 2);
    wait_scan();
    repeat (30) @(negedge clk);
    reset_sw = 1'b1;
    #1;
    check("midrst_col",     {4'h0, col},      8'h0E);
    check("midrst_code",    {4'h0, key_code}, 8'h00);
    check("midrst_valid",   {7'd0, key_valid}, 8'h00);
    check("midrst_held",    {7'd0, key_held},  8'h00);
    check("midrst_overrun", {7'd0, overrun},   8'h00);
    repeat (2) @(negedge clk);
    reset_sw = 1'b0;
    exp_q.push_back({4'h9, 1'b0});
    repeat (2) wait_scan();
    settle();
    check("k9_valid", {7'd0, key_valid}, 8'h01);
    check("k9_code",  {4'h0, key_code}, 8'h09);
    check("k9_held",  {7'd0, key_held},  8'h01);
    ready_pulse();
    @(negedge clk);
    check("k9_hs_clear", {7'd0, key_valid}, 8'h00);
    release_all("k9_released");

    check("queue_drained", exp_q.size() == 0 ? 8'h01 : 8'h00, 8'h01);
    check("event_count", rises[7:0], 8'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
